// File: rtl/muldiv_if.sv
// muldiv_if: request/response bundle between the pipeline control and the
// iterative multiply/divide unit.
//   start, op, a, b   launch request (op: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV)
//   mthi, mtlo, wd    direct writes into HI/LO
//   busy, done        operation in progress / one-cycle completion pulse
//   hi, lo            architectural HI/LO registers
// master = requester (control FSM / testbench), slave = muldiv_unit.
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] wd;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, mthi, mtlo, wd,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, mthi, mtlo, wd,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative WIDTH-bit multiply/divide unit owning HI/LO.
// One shared 2*WIDTH-bit accumulator does radix-2 shift-add multiply and
// restoring division, one iteration per clock, WIDTH iterations per op.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high; clears HI/LO, aborts any operation
//   bus    muldiv_if.slave (start/op/a/b, mthi/mtlo/wd, busy/done/hi/lo)
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     reset,
    muldiv_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state, state_nxt;
    logic               launch, finish;
    logic [CW-1:0]      cnt;

    logic               is_div, neg_q, neg_r, div_zero;
    logic [WIDTH-1:0]   opa;   // multiplier (shifts right) or dividend (shifts left)
    logic [WIDTH-1:0]   opb;   // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0] acc;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH+1:0]   trial;
    logic               borrow;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot, rem;
    logic               mt_ok;

    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] x,
                                                   input logic is_signed);
        // The most negative value maps onto itself, which is the correct
        // unsigned magnitude.
        return (is_signed && x[WIDTH-1]) ? WIDTH'(-x) : WIDTH'(x);
    endfunction

    function automatic logic [WIDTH-1:0] fix_sign(input logic [WIDTH-1:0] x, input logic neg);
        return neg ? WIDTH'(-x) : x;
    endfunction

    function automatic logic [2*WIDTH-1:0] fix_sign_wide(input logic [2*WIDTH-1:0] x, input logic neg);
        return neg ? (2*WIDTH)'(-x) : x;
    endfunction

    // Control FSM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: if (bus.start) begin
                launch    = 1'b1;
                state_nxt = RUN;
            end
            RUN: if (cnt == LAST) begin
                finish    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.busy = (state == RUN);
    assign mt_ok    = (state == IDLE) && !bus.start;

    // One iteration of the shared datapath
    always_comb begin
        mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (opa[0] ? {1'b0, opb} : '0);
        // Dividend bits enter the remainder from opa; quotient bits enter at
        // the bottom of the lower half.
        rem_sh  = {acc[2*WIDTH-1:WIDTH], opa[WIDTH-1]};
        trial   = {1'b0, rem_sh} - {2'b00, opb};
        borrow  = trial[WIDTH+1];
        if (is_div)
            acc_nxt = {(borrow ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0]),
                       acc[WIDTH-2:0], ~borrow};
        else
            acc_nxt = {mul_sum, acc[WIDTH-1:1]};

        prod = fix_sign_wide(acc_nxt, neg_q);
        // A zero divisor never borrows, so the remainder path ends up holding
        // |a|; re-applying the dividend's sign reproduces a unchanged.
        rem  = fix_sign(acc_nxt[2*WIDTH-1:WIDTH], neg_r);
        quot = div_zero ? '1 : fix_sign(acc_nxt[WIDTH-1:0], neg_q);
    end

    // Operand and accumulator registers (data only, no reset)
    always_ff @(posedge clk) begin
        if (launch) begin
            opa      <= magnitude(bus.a, bus.op[0]);
            opb      <= magnitude(bus.b, bus.op[0]);
            neg_q    <= bus.op[0] & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            neg_r    <= bus.op[0] & bus.a[WIDTH-1];
            is_div   <= bus.op[1];
            div_zero <= (bus.b == '0);
            acc      <= '0;
        end else if (state == RUN) begin
            acc <= acc_nxt;
            opa <= is_div ? {opa[WIDTH-2:0], 1'b0} : {1'b0, opa[WIDTH-1:1]};
        end
    end

    // Architectural state: counter, done pulse, HI/LO
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            bus.done <= 1'b0;
            bus.hi <= '0;
            bus.lo <= '0;
        end else begin
            bus.done <= finish;
            if (launch)
                cnt <= '0;
            else if (state == RUN)
                cnt <= cnt + 1'b1;

            if (finish) begin
                bus.hi <= is_div ? rem  : prod[2*WIDTH-1:WIDTH];
                bus.lo <= is_div ? quot : prod[WIDTH-1:0];
            end else begin
                if (mt_ok && bus.mthi) bus.hi <= bus.wd;
                if (mt_ok && bus.mtlo) bus.lo <= bus.wd;
            end
        end
    end
endmodule
